// File: rtl/nios_multi_timer.sv
// rtl/nios_multi_timer.sv - multi-channel Avalon-MM interval timer with per-channel IRQs
// Optional timeout_pulse output is built when NIOS_MULTI_TIMER_PULSE_OUT_EN is defined.
module nios_multi_timer #(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 32,
    parameter int unsigned RESET_PERIOD = 49999999,
    parameter int          AW           = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
`ifdef NIOS_MULTI_TIMER_PULSE_OUT_EN
    ,
    output logic [NUM_CH-1:0] timeout_pulse
`endif
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
    localparam int               CHW   = (AW > 2) ? AW - 2 : 1;

    logic [CHW-1:0] ch_sel;
    logic [1:0]     reg_sel;

    assign reg_sel = address[1:0];

    generate
        if (AW > 2) begin : g_ch_sel
            assign ch_sel = address[AW-1:2];
        end else begin : g_ch_single
            assign ch_sel = '0;
        end
    endgenerate

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
    logic [NUM_CH-1:0][15:0]      presc_q, presc_d;
    logic [NUM_CH-1:0][3:0]       ps_q, ps_d;
    logic [NUM_CH-1:0]            run_q, run_d, to_q, to_d, ito_q, ito_d;
    logic [NUM_CH-1:0]            cont_q, cont_d, frl_q, frl_d, nz_q, nz_d;
    logic [NUM_CH-1:0]            wr_ch, tick, tmo, start_c, stop_c, wr_status_c, wr_period_c;
    logic [31:0]                  readdata_q, readdata_d;

    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        snap_d      = snap_q;
        presc_d     = presc_q;
        ps_d        = ps_q;
        run_d       = run_q;
        to_d        = to_q;
        ito_d       = ito_q;
        cont_d      = cont_q;
        frl_d       = '0;
        nz_d        = nz_q;
        wr_ch       = '0;
        tick        = '0;
        tmo         = '0;
        start_c     = '0;
        stop_c      = '0;
        wr_status_c = '0;
        wr_period_c = '0;
        readdata_d  = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i]       = chipselect && !write_n && (int'(ch_sel) == i);
            wr_status_c[i] = wr_ch[i] && (reg_sel == 2'd0);
            wr_period_c[i] = wr_ch[i] && (reg_sel == 2'd2);
            start_c[i]     = wr_ch[i] && (reg_sel == 2'd1) && writedata[2];
            stop_c[i]      = wr_ch[i] && (reg_sel == 2'd1) && writedata[3];

            if (wr_ch[i] && (reg_sel == 2'd1)) begin
                ito_d[i]  = writedata[0];
                cont_d[i] = writedata[1];
                ps_d[i]   = writedata[7:4];
            end
            if (wr_period_c[i]) begin
                period_d[i] = writedata[CNT_W-1:0];
            end
            if (wr_ch[i] && (reg_sel == 2'd3)) begin
                snap_d[i] = cnt_q[i];
            end

            // >= rather than == so lowering PS mid-count cannot strand the prescaler
            tick[i] = presc_q[i] >= ((16'd1 << ps_q[i]) - 16'd1);
            if (start_c[i] || wr_period_c[i] || tick[i]) begin
                presc_d[i] = '0;
            end else begin
                presc_d[i] = presc_q[i] + 16'd1;
            end

            if (frl_q[i]) begin
                cnt_d[i] = period_q[i];
            end else if (run_q[i] && tick[i]) begin
                cnt_d[i] = (cnt_q[i] == '0) ? period_q[i] : cnt_q[i] - CNT_W'(1);
            end

            // One-shot stops on the reload tick, so the counter rests at PERIOD
            if (start_c[i]) begin
                run_d[i] = 1'b1;
            end else if (stop_c[i] || frl_q[i] ||
                         (run_q[i] && tick[i] && (cnt_q[i] == '0) && !cont_q[i])) begin
                run_d[i] = 1'b0;
            end

            frl_d[i] = wr_period_c[i];
            nz_d[i]  = (cnt_q[i] != '0);
            tmo[i]   = (cnt_q[i] == '0) && nz_q[i];
            to_d[i]  = tmo[i] || (to_q[i] && !wr_status_c[i]);

            if (int'(ch_sel) == i) begin
                case (reg_sel)
                    2'd0:    readdata_d = {30'd0, run_q[i], to_q[i]};
                    2'd1:    readdata_d = {24'd0, ps_q[i], 2'b00, cont_q[i], ito_q[i]};
                    2'd2:    readdata_d = 32'(period_q[i]);
                    default: readdata_d = 32'(snap_q[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= {NUM_CH{RST_P}};
            period_q   <= {NUM_CH{RST_P}};
            snap_q     <= '0;
            presc_q    <= '0;
            ps_q       <= '0;
            run_q      <= '0;
            to_q       <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            frl_q      <= '0;
            nz_q       <= {NUM_CH{RST_P != '0}};
            readdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            presc_q    <= presc_d;
            ps_q       <= ps_d;
            run_q      <= run_d;
            to_q       <= to_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            frl_q      <= frl_d;
            nz_q       <= nz_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_vec  = to_q & ito_q;
    assign irq      = |irq_vec;

`ifdef NIOS_MULTI_TIMER_PULSE_OUT_EN
    logic [NUM_CH-1:0] pulse_q, pulse_d;

    assign pulse_d = tmo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign timeout_pulse = pulse_q;
`endif

endmodule
